// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory port arbiter with tagged read returns
// Burst-capped fairness between core and loader; read owner tags ride an RD_LAT-deep pipe.
module mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_adr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_adr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_CORE, S_DBG} state_t;

    localparam logic [2:0] CAP = 3'(MAX_BURST);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_dbg_q, last_dbg_d;
    logic        win_core, win_dbg;
    logic        below_cap;
    logic        acc_rd;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RD_LAT-1:0] rd_dbg_q;

    assign below_cap = (cnt_q < CAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            last_dbg_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    always_comb begin
        win_core = 1'b0;
        win_dbg  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_req && dbg_req) begin
                    win_core = last_dbg_q;
                    win_dbg  = ~last_dbg_q;
                end else begin
                    win_core = core_req;
                    win_dbg  = dbg_req;
                end
            end
            S_CORE: begin
                win_core = core_req & (~dbg_req | below_cap);
                win_dbg  = ~win_core & dbg_req;
            end
            S_DBG: begin
                win_dbg  = dbg_req & (~core_req | below_cap);
                win_core = ~win_dbg & core_req;
            end
            default: ;
        endcase

        state_d = win_core ? S_CORE : (win_dbg ? S_DBG : S_IDLE);

        // cnt saturates so a lone requester keeps its tenure without wrapping
        if (state_d == S_IDLE)
            cnt_d = 3'd0;
        else if (state_d == state_q)
            cnt_d = below_cap ? cnt_q + 3'd1 : cnt_q;
        else
            cnt_d = 3'd1;

        last_dbg_d = (win_core | win_dbg) ? win_dbg : last_dbg_q;
    end

    always_comb begin
        core_gnt   = win_core & ~reset;
        dbg_gnt    = win_dbg & ~reset;
        core_stall = core_req & ~core_gnt;
        mem_adr    = win_dbg ? dbg_adr : core_adr;
        mem_wdata  = win_dbg ? dbg_wdata : core_wdata;
        mem_we     = ~reset & ((win_core & core_we) | (win_dbg & dbg_we));
        acc_rd     = (win_core & ~core_we) | (win_dbg & ~dbg_we);
        rdata      = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q <= '0;
            rd_dbg_q <= '0;
        end else begin
            rd_vld_q[0] <= acc_rd;
            rd_dbg_q[0] <= win_dbg;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dbg_q[i] <= rd_dbg_q[i-1];
            end
        end
    end

    assign core_rvalid = rd_vld_q[RD_LAT-1] & ~rd_dbg_q[RD_LAT-1];
    assign dbg_rvalid  = rd_vld_q[RD_LAT-1] & rd_dbg_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a tenure model
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dbg_req, dbg_we;
    logic [DW-1:0] core_adr, core_wdata, dbg_adr, dbg_wdata;
    logic          core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] rdata, mem_adr, mem_wdata, mem_rdata;
    logic          mem_we;

    mem_arbiter #(.DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: owner 0=none 1=core 2=dbg; run is an unbounded tenure length
    int m_owner, m_run, m_last;
    int m_pipe[$];

    logic          obs_cg, obs_dg, obs_cs, obs_cr, obs_dr, obs_we;
    logic [DW-1:0] obs_adr, obs_wd;
    logic [11:0]   cg_pat, cs_pat;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_run   = 0;
        m_last  = 2;
        m_pipe.delete();
        for (int i = 0; i < RL; i++) m_pipe.push_back(0);
    endtask

    function automatic int pick(input bit cr, input bit dr);
        bit own_req, oth_req;
        if (m_owner == 0) begin
            if (cr && dr) return (m_last == 2) ? 1 : 2;
            if (cr) return 1;
            if (dr) return 2;
            return 0;
        end
        own_req = (m_owner == 1) ? cr : dr;
        oth_req = (m_owner == 1) ? dr : cr;
        if (own_req && (!oth_req || m_run < MB)) return m_owner;
        if (oth_req) return 3 - m_owner;
        return 0;
    endfunction

    task automatic cycle(input bit cr, input bit cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                         input bit dr, input bit dw, input logic [DW-1:0] da, input logic [DW-1:0] dd,
                         input logic [DW-1:0] rd);
        int w;
        bit ewe;
        @(negedge clk);
        core_req = cr; core_we = cw; core_adr = ca; core_wdata = cd;
        dbg_req = dr;  dbg_we = dw;  dbg_adr = da;  dbg_wdata = dd;
        mem_rdata = rd;
        #2;
        w   = pick(cr, dr);
        ewe = (w == 1) ? cw : ((w == 2) ? dw : 1'b0);
        check("core_gnt", core_gnt, w == 1);
        check("dbg_gnt", dbg_gnt, w == 2);
        check("core_stall", core_stall, cr && (w != 1));
        check("mem_we", mem_we, ewe);
        check("mem_adr", mem_adr, (w == 2) ? da : ca);
        check("mem_wdata", mem_wdata, (w == 2) ? dd : cd);
        check("core_rvalid", core_rvalid, m_pipe[0] == 1);
        check("dbg_rvalid", dbg_rvalid, m_pipe[0] == 2);
        check("rdata", rdata, rd);
        obs_cg = core_gnt; obs_dg = dbg_gnt; obs_cs = core_stall;
        obs_cr = core_rvalid; obs_dr = dbg_rvalid;
        obs_we = mem_we; obs_adr = mem_adr; obs_wd = mem_wdata;
        @(posedge clk);
        void'(m_pipe.pop_front());
        m_pipe.push_back(((w == 1 && !cw) || (w == 2 && !dw)) ? w : 0);
        if (w == 0) m_run = 0;
        else if (w == m_owner) m_run++;
        else m_run = 1;
        m_owner = w;
        if (w != 0) m_last = w;
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, 0, 0, '0, '0, $urandom);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        core_req = 1; core_we = 0; dbg_req = 1; dbg_we = 0;
        reset = 1'b1;
        #1;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rvalid", core_rvalid | dbg_rvalid, 0);
        model_reset();
        @(negedge clk);
        core_req = 0; dbg_req = 0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        core_req = 0; core_we = 0; core_adr = '0; core_wdata = '0;
        dbg_req = 0;  dbg_we = 0;  dbg_adr = '0;  dbg_wdata = '0;
        mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_core_gnt", core_gnt, 0);
        check("reset_dbg_gnt", dbg_gnt, 0);
        check("reset_stall", core_stall, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_rvalid", core_rvalid | dbg_rvalid, 0);
        reset = 1'b0;

        // first tie after reset goes to the core; dbg follows once core drops
        cycle(1, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2, $urandom);
        check("tie_core_gnt", obs_cg, 1);
        check("tie_dbg_gnt", obs_dg, 0);
        cycle(0, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2, $urandom);
        check("tie_then_dbg", obs_dg, 1);
        idle();

        cg_pat = '0; cs_pat = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 32'h100, $urandom, 1, 1, 32'h200, $urandom, $urandom);
            cg_pat = {cg_pat[10:0], obs_cg};
            cs_pat = {cs_pat[10:0], obs_cs};
        end
        check("burst_core_pattern", {20'h0, cg_pat}, 32'hF0F);
        check("burst_stall_pattern", {20'h0, cs_pat}, 32'h0F0);
        idle();

        cycle(0, 0, '0, '0, 1, 1, 32'h20, 32'hE3A0B005, $urandom);
        check("ldr_we", obs_we, 1);
        check("ldr_adr", obs_adr, 32'h20);
        check("ldr_wdata", obs_wd, 32'hE3A0B005);
        idle();
        check("ldr_we_drops", obs_we, 0);

        cycle(1, 0, 32'h10, '0, 0, 0, '0, '0, $urandom);
        check("lone_gnt", obs_cg, 1);
        for (int j = 1; j <= RL + 1; j++) begin
            cycle(0, 0, '0, '0, 0, 0, '0, '0, (j == RL) ? 32'hDEADBEEF : $urandom);
            check("lone_core_rv", obs_cr, j == RL);
            check("lone_dbg_rv", obs_dr, 0);
        end

        cycle(1, 0, 32'h30, '0, 0, 0, '0, '0, $urandom);
        for (int j = 1; j <= RL + 3; j++) begin
            if (j == 1) cycle(0, 0, '0, '0, 1, 0, 32'h40, '0, $urandom);
            else idle();
            check("lat_core_rv", obs_cr, j == RL);
            check("lat_dbg_rv", obs_dr, j == RL + 1);
        end

        cycle(1, 0, 32'h50, '0, 0, 0, '0, '0, $urandom);
        reset_pulse();
        for (int j = 0; j < RL + 1; j++) begin
            idle();
            check("rst_no_rv", obs_cr, 0);
        end
        cycle(1, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2, $urandom);
        check("rst_tie_core", obs_cg, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
